// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers.
//   NOP_WORD  : encoding of a MIPS nop; a bubble drives this on the instruction field
//   INSTR_LSB : bit offset of the instruction word in the IF/ID payload
//   PC_LSB    : bit offset of the next-PC word in the IF/ID payload
//   occ_e     : buffer occupancy state, numerically equal to the number of held entries
package pipe_pkg;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam int unsigned INSTR_LSB = 0;
    localparam int unsigned PC_LSB    = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
//   clk     : clock, rising edge
//   reset   : synchronous clear to zero
//   i_en    : count enable; counter holds at all-ones once reached
//   o_count : current count
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and stall counter.
//   clk, reset          : clock and synchronous active-high reset
//   flush               : drop every held entry (branch/jump redirect)
//   in_valid/in_ready   : upstream handshake, in_data accepted when both high
//   out_valid/out_ready : downstream handshake, out_data consumed when both high
//   out_data            : held payload, all-zero (nop) when out_valid is low
//   occupancy           : number of held entries (0..2)
//   stall_cnt           : saturating count of cycles with out_valid & ~out_ready
// SKID=1 gives a 2-entry skid buffer whose in_ready depends on registered state only;
// SKID=0 gives a single register whose in_ready follows out_ready combinationally.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    import pipe_pkg::*;

    logic              w_push;
    logic              w_pop;
    logic              w_main_v;
    logic [DATA_W-1:0] w_main_d;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    if (SKID != 0) begin : g_skid
        // The skid entry is valid exactly when the state is TWO.
        occ_e              r_state;
        occ_e              w_state_nxt;
        logic [DATA_W-1:0] r_main_d;
        logic [DATA_W-1:0] r_skid_d;
        logic [DATA_W-1:0] w_main_d_nxt;
        logic [DATA_W-1:0] w_skid_d_nxt;

        always_ff @(posedge clk) begin
            if (reset || flush) begin
                r_state  <= EMPTY;
                r_main_d <= '0;
                r_skid_d <= '0;
            end else begin
                r_state  <= w_state_nxt;
                r_main_d <= w_main_d_nxt;
                r_skid_d <= w_skid_d_nxt;
            end
        end

        always_comb begin
            w_state_nxt  = r_state;
            w_main_d_nxt = r_main_d;
            w_skid_d_nxt = r_skid_d;
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        w_state_nxt  = ONE;
                        w_main_d_nxt = in_data;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        w_main_d_nxt = in_data;
                    end else if (w_push) begin
                        w_state_nxt  = TWO;
                        w_skid_d_nxt = in_data;
                    end else if (w_pop) begin
                        w_state_nxt  = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a pop can happen.
                    if (w_pop) begin
                        w_state_nxt  = ONE;
                        w_main_d_nxt = r_skid_d;
                        w_skid_d_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end

        assign w_main_v  = (r_state != EMPTY);
        assign w_main_d  = r_main_d;
        assign in_ready  = (r_state != TWO);
        assign occupancy = r_state;
    end else begin : g_single
        logic              r_main_v;
        logic [DATA_W-1:0] r_main_d;

        always_ff @(posedge clk) begin
            if (reset || flush) begin
                r_main_v <= 1'b0;
                r_main_d <= '0;
            end else if (w_push) begin
                r_main_v <= 1'b1;
                r_main_d <= in_data;
            end else if (w_pop) begin
                r_main_v <= 1'b0;
            end
        end

        assign w_main_v  = r_main_v;
        assign w_main_d  = r_main_d;
        assign in_ready  = ~reset & (~r_main_v | out_ready);
        assign occupancy = {1'b0, r_main_v};
    end

    assign out_valid = w_main_v;
    assign out_data  = w_main_v ? w_main_d : '0;

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_stall_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_en   (out_valid & ~out_ready),
        .o_count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: a SKID=1 and a SKID=0 instance plus a SKID=1
// instance with a 4-bit stall counter, all fed from the same upstream/downstream signals.
module tb_pipe_stage_skid;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;

    logic        o1_in_ready, o1_valid;
    logic [63:0] o1_data;
    logic [1:0]  o1_occ;
    logic [15:0] o1_stall;

    logic        o0_in_ready, o0_valid;
    logic [63:0] o0_data;
    logic [1:0]  o0_occ;
    logic [15:0] o0_stall;

    logic        os_in_ready, os_valid;
    logic [63:0] os_data;
    logic [1:0]  os_occ;
    logic [3:0]  os_stall;

    int n_pass  = 0;
    int n_total = 0;
    bit mon_en  = 0;

    pipe_stage_skid #(.DATA_W(64), .SKID(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(o1_in_ready),
        .in_data(in_data), .out_valid(o1_valid), .out_ready(out_ready), .out_data(o1_data),
        .occupancy(o1_occ), .stall_cnt(o1_stall)
    );

    pipe_stage_skid #(.DATA_W(64), .SKID(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(o0_in_ready),
        .in_data(in_data), .out_valid(o0_valid), .out_ready(out_ready), .out_data(o0_data),
        .occupancy(o0_occ), .stall_cnt(o0_stall)
    );

    pipe_stage_skid #(.DATA_W(64), .SKID(1), .CNT_W(4)) u_duts (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(os_in_ready),
        .in_data(in_data), .out_valid(os_valid), .out_ready(out_ready), .out_data(os_data),
        .occupancy(os_occ), .stall_cnt(os_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: expected payloads per instance, pushed on accepted input, popped on output.
    logic [63:0] q1[$];
    logic [63:0] q0[$];
    logic [63:0] exp_d;
    logic [15:0] m1_cnt = '0;
    logic [15:0] m0_cnt = '0;
    logic [3:0]  ms_cnt = '0;
    bit          v1, v0, r1, r0;

    always @(negedge clk) begin
        if (mon_en) begin
            v1 = (q1.size() != 0);
            v0 = (q0.size() != 0);
            r1 = (q1.size() < 2);
            r0 = !reset && ((q0.size() == 0) || out_ready);

            n_total++;
            if (o1_valid !== v1) $display("FAIL sb1_valid: got %0b want %0b", o1_valid, v1);
            else n_pass++;
            n_total++;
            if (o1_in_ready !== r1) $display("FAIL sb1_in_ready: got %0b want %0b", o1_in_ready, r1);
            else n_pass++;
            n_total++;
            if (o1_occ !== 2'(q1.size())) $display("FAIL sb1_occ: got %0d want %0d", o1_occ, q1.size());
            else n_pass++;
            n_total++;
            if (o1_stall !== m1_cnt) $display("FAIL sb1_stall: got %0d want %0d", o1_stall, m1_cnt);
            else n_pass++;
            n_total++;
            if (os_valid !== v1) $display("FAIL sbs_valid: got %0b want %0b", os_valid, v1);
            else n_pass++;
            n_total++;
            if (os_stall !== ms_cnt) $display("FAIL sbs_stall: got %0d want %0d", os_stall, ms_cnt);
            else n_pass++;
            if (!v1) begin
                n_total++;
                if (o1_data !== 64'h0) $display("FAIL sb1_bubble: got %h want 0", o1_data);
                else n_pass++;
            end
            if (v1 && out_ready) begin
                exp_d = q1.pop_front();
                n_total++;
                if (o1_data !== exp_d) $display("FAIL sb1_data: got %h want %h", o1_data, exp_d);
                else n_pass++;
            end
            if (in_valid && r1 && !flush && !reset) q1.push_back(in_data);
            if (flush || reset) q1.delete();

            n_total++;
            if (o0_valid !== v0) $display("FAIL sb0_valid: got %0b want %0b", o0_valid, v0);
            else n_pass++;
            n_total++;
            if (o0_in_ready !== r0) $display("FAIL sb0_in_ready: got %0b want %0b", o0_in_ready, r0);
            else n_pass++;
            n_total++;
            if (o0_occ !== 2'(q0.size())) $display("FAIL sb0_occ: got %0d want %0d", o0_occ, q0.size());
            else n_pass++;
            n_total++;
            if (o0_stall !== m0_cnt) $display("FAIL sb0_stall: got %0d want %0d", o0_stall, m0_cnt);
            else n_pass++;
            if (!v0) begin
                n_total++;
                if (o0_data !== 64'h0) $display("FAIL sb0_bubble: got %h want 0", o0_data);
                else n_pass++;
            end
            if (v0 && out_ready) begin
                exp_d = q0.pop_front();
                n_total++;
                if (o0_data !== exp_d) $display("FAIL sb0_data: got %h want %h", o0_data, exp_d);
                else n_pass++;
            end
            if (in_valid && r0 && !flush && !reset) q0.push_back(in_data);
            if (flush || reset) q0.delete();

            if (reset) begin
                m1_cnt = '0;
                m0_cnt = '0;
                ms_cnt = '0;
            end else begin
                if (v1 && !out_ready && m1_cnt != 16'hFFFF) m1_cnt = m1_cnt + 16'd1;
                if (v0 && !out_ready && m0_cnt != 16'hFFFF) m0_cnt = m0_cnt + 16'd1;
                if (v1 && !out_ready && ms_cnt != 4'hF) ms_cnt = ms_cnt + 4'd1;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();
        n_total++;
        if (o1_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", o1_valid); else n_pass++;
        n_total++;
        if (o1_occ !== 2'd0) $display("FAIL reset_occ: got %0d want 0", o1_occ); else n_pass++;
        n_total++;
        if (o1_stall !== 16'd0) $display("FAIL reset_stall: got %0d want 0", o1_stall); else n_pass++;
        n_total++;
        if (o1_in_ready !== 1'b1) $display("FAIL reset_rdy1: got %0b want 1", o1_in_ready); else n_pass++;
        n_total++;
        if (o0_in_ready !== 1'b0) $display("FAIL reset_rdy0: got %0b want 0", o0_in_ready); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_stream;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            tick();
            n_total++;
            if (o1_data !== 64'(i)) $display("FAIL stream_data1: got %h want %h", o1_data, 64'(i));
            else n_pass++;
            n_total++;
            if (o0_data !== 64'(i)) $display("FAIL stream_data0: got %h want %h", o0_data, 64'(i));
            else n_pass++;
            n_total++;
            if (o1_occ !== 2'd1) $display("FAIL stream_occ: got %0d want 1", o1_occ); else n_pass++;
        end
        in_valid = 1'b0;
        tick();
        n_total++;
        if (o1_valid !== 1'b0) $display("FAIL stream_drain: got %0b want 0", o1_valid); else n_pass++;
        n_total++;
        if (o1_stall !== 16'd0) $display("FAIL stream_stall: got %0d want 0", o1_stall); else n_pass++;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'hAA;
        tick();
        in_data = 64'hBB;
        tick();
        n_total++;
        if (o1_occ !== 2'd2) $display("FAIL bp_occ2: got %0d want 2", o1_occ); else n_pass++;
        n_total++;
        if (o1_in_ready !== 1'b0) $display("FAIL bp_rdy: got %0b want 0", o1_in_ready); else n_pass++;
        n_total++;
        if (o0_in_ready !== 1'b0) $display("FAIL bp_rdy0: got %0b want 0", o0_in_ready); else n_pass++;
        in_valid = 1'b0;
        tick();
        n_total++;
        if (o1_data !== 64'hAA) $display("FAIL bp_hold: got %h want aa", o1_data); else n_pass++;
        n_total++;
        if (o1_stall !== 16'd2) $display("FAIL bp_stall: got %0d want 2", o1_stall); else n_pass++;
        out_ready = 1'b1;
        tick();
        n_total++;
        if (o1_data !== 64'hBB) $display("FAIL bp_second: got %h want bb", o1_data); else n_pass++;
        n_total++;
        if (o1_in_ready !== 1'b1) $display("FAIL bp_rdy_back: got %0b want 1", o1_in_ready); else n_pass++;
        tick();
        n_total++;
        if (o1_occ !== 2'd0) $display("FAIL bp_empty: got %0d want 0", o1_occ); else n_pass++;
    endtask

    task automatic test_flush_two;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h11;
        tick();
        in_data = 64'h22;
        tick();
        flush = 1'b1; in_data = 64'hCC; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_total++;
        if (o1_valid !== 1'b0) $display("FAIL flush_valid: got %0b want 0", o1_valid); else n_pass++;
        n_total++;
        if (o1_data !== 64'h0) $display("FAIL flush_data: got %h want 0", o1_data); else n_pass++;
        n_total++;
        if (o1_occ !== 2'd0) $display("FAIL flush_occ: got %0d want 0", o1_occ); else n_pass++;
        n_total++;
        if (o1_stall !== 16'd3) $display("FAIL flush_stall: got %0d want 3", o1_stall); else n_pass++;
        n_total++;
        if (o0_valid !== 1'b0) $display("FAIL flush_valid0: got %0b want 0", o0_valid); else n_pass++;
        tick();
        tick();
        n_total++;
        if (o1_valid !== 1'b0) $display("FAIL flush_no_cc: got %0b want 0", o1_valid); else n_pass++;
    endtask

    task automatic test_reset_beats_flush;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h33;
        tick();
        in_data = 64'h44;
        tick();
        reset = 1'b1; flush = 1'b1; in_data = 64'h99;
        tick();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        n_total++;
        if (o1_occ !== 2'd0) $display("FAIL rbf_occ: got %0d want 0", o1_occ); else n_pass++;
        n_total++;
        if (o1_valid !== 1'b0) $display("FAIL rbf_valid: got %0b want 0", o1_valid); else n_pass++;
        n_total++;
        if (o1_stall !== 16'd0) $display("FAIL rbf_stall: got %0d want 0", o1_stall); else n_pass++;
    endtask

    task automatic test_skid0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h55;
        tick();
        n_total++;
        if (o0_in_ready !== 1'b0) $display("FAIL s0_full_rdy: got %0b want 0", o0_in_ready); else n_pass++;
        out_ready = 1'b1; in_data = 64'h66;
        #1;
        n_total++;
        if (o0_in_ready !== 1'b1) $display("FAIL s0_comb_rdy: got %0b want 1", o0_in_ready); else n_pass++;
        tick();
        n_total++;
        if (o0_valid !== 1'b1) $display("FAIL s0_no_bubble: got %0b want 1", o0_valid); else n_pass++;
        n_total++;
        if (o0_data !== 64'h66) $display("FAIL s0_replace: got %h want 66", o0_data); else n_pass++;
        n_total++;
        if (o0_occ !== 2'd1) $display("FAIL s0_occ: got %0d want 1", o0_occ); else n_pass++;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_saturation;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h77;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        n_total++;
        if (os_stall !== 4'd15) $display("FAIL sat_cnt4: got %0d want 15", os_stall); else n_pass++;
        n_total++;
        if (o1_stall !== 16'd20) $display("FAIL sat_cnt16: got %0d want 20", o1_stall); else n_pass++;
        n_total++;
        if (os_data !== 64'h77) $display("FAIL sat_hold: got %h want 77", os_data); else n_pass++;
        out_ready = 1'b1;
        tick();
        n_total++;
        if (os_valid !== 1'b0) $display("FAIL sat_drain: got %0b want 0", os_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_two();
        test_reset_beats_flush();
        test_skid0();
        test_saturation();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register for the MIPS pipeline boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces single-purpose stage registers that use a bare hazard hold: uses a valid/ready handshake, a synchronous flush that inserts a bubble, an optional 2-entry skid buffer that breaks the combinational ready path, and a saturating stall counter for performance analysis.

Parameters:
- DATA_W, 64, payload width in bits (for IF/ID: instruction[31:0] plus next-PC[63:32]).
- SKID, 1, selects the buffer mode. 1 = 2-entry skid buffer with registered in_ready. 0 = single register with combinational in_ready.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous; discards all held entries (branch/jump redirect).
- in_valid  input  1  upstream holds a valid payload.
- in_ready  output  1  stage accepts in_data this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  DATA_W  payload; all-zero when out_valid=0 (zero = MIPS nop, so a bubble is a nop).
- occupancy  output  2  number of held entries (0..2).
- stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Transfer rules: push = in_valid & in_ready; pop = out_valid & out_ready.
- Storage: main register (main_v, main_d) drives the outputs; skid register (skid_v, skid_d) exists only when SKID=1.
- Output drive: out_valid = main_v; out_data = main_v ? main_d : 0.
- Latency: exactly 1 cycle from push to out_valid, in either mode. Payload order is strictly preserved.
- SKID=1 state machine, state = occupancy:
  - EMPTY: push -> ONE (main_d <= in_data). No push -> EMPTY.
  - ONE: push & pop -> ONE (main_d <= in_data). Push only -> TWO (skid_d <= in_data). Pop only -> EMPTY. Neither -> ONE.
  - TWO: in_ready=0, so no push is possible. Pop -> ONE (main_d <= skid_d, skid_v <= 0). No pop -> TWO.
  - in_ready = (state != TWO), a function of registered state only. There is no path from out_ready to in_ready.
- SKID=0 mode:
  - in_ready = ~main_v | out_ready (combinational).
  - Push loads main; pop without push clears main_v.
  - occupancy is never greater than 1.
- Flush:
  - Takes priority over push and pop in the same cycle. Next cycle: main_v=0, skid_v=0, data registers = 0, occupancy=0.
  - A push coincident with flush is discarded; upstream must treat it as consumed.
  - A pop coincident with flush completes normally from the downstream side (the payload was sampled).
- Reset:
  - Highest priority, including over flush. Next cycle: main_v=0, skid_v=0, all data = 0, occupancy=0, stall_cnt=0.
  - During reset, in_ready=0 in SKID=0 mode; in SKID=1 mode in_ready follows state and is 1 after reset.
  - Reset mid-transfer drops all held payloads.
- stall_cnt:
  - Increments when out_valid & ~out_ready, saturating at 2^CNT_W-1.
  - Cleared only by reset; flush does not clear it.
- Protocol assumptions on neighbours:
  - Upstream holds in_data stable while in_valid & ~in_ready.
  - This block holds out_data stable while out_valid & ~out_ready. A violation of this is a bug in the block.
- An entry is never lost or duplicated except through flush or reset.

Decomposition:
- Shared package pipe_pkg holds:
  - constant NOP_WORD = 32'h0000_0000;
  - IF/ID payload field offsets (INSTR_LSB=0, PC_LSB=32);
  - typedef for occupancy state (EMPTY=0, ONE=1, TWO=2).
- One natural sub-module: sat_counter (parametrised width, enable, synchronous reset), used for stall_cnt.
- The buffer FSM stays inline, with SKID=0 / SKID=1 selected by a generate block.

Test Plan:
- Reset, then stream: reset 2 cycles, then in_valid=1 with data 0x1 to 0x8 on consecutive cycles and out_ready=1 -> each value appears on out_data exactly 1 cycle after its push, in order; occupancy=1 throughout; stall_cnt=0.
- Backpressure fill (SKID=1): push A=0xAA, then B=0xBB with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xAA held. Raise out_ready -> A, then B, leave on successive cycles; in_ready returns to 1 one cycle after the first pop; stall_cnt increases by the number of stalled cycles.
- Flush in TWO: occupancy=2, assert flush together with in_valid=1 (data 0xCC) -> next cycle out_valid=0, out_data=0, occupancy=0; 0xCC is never emitted; stall_cnt is unchanged.
- Reset beats flush: from occupancy=2, assert reset and flush together -> next cycle occupancy=0, out_valid=0, stall_cnt=0.
- SKID=0 mode: out_ready=0 with main full -> in_ready=0 in the same cycle. Set out_ready=1 with in_valid=1 -> in_ready=1 combinationally, and the new word replaces the old one with no bubble.
- Saturation with CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt stops at 15.
